// File: rtl/rot_serializer.sv
// rot_serializer: one-word buffer plus MSB-first framed serial shifter.
// Optional even-parity trailer bit enabled by defining PARITY_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module rot_serializer #(
  parameter int WIDTH = `DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             accept;
  logic             last_bit;
`ifdef PARITY_EN
  logic             par;
`endif

  assign accept   = din_valid & ~hold_full;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and buffer-to-shifter transfer decision
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef PARITY_EN
          state_n = PAR;
`else
          if (hold_full) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
`endif
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Holding buffer, shift register and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
`ifdef PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        shreg <= hold;
        cnt   <= '0;
`ifdef PARITY_EN
        par   <= ^hold;
`endif
      end else if (state == SHIFT) begin
        shreg <= shreg << 1;
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    din_ready   = ~hold_full;
    sdo_valid   = (state != IDLE);
    busy        = (state != IDLE) | hold_full;
    frame_start = (state == SHIFT) && (cnt == '0);
    sdo         = 1'b0;
`ifdef PARITY_EN
    frame_end   = (state == PAR);
    if (state == SHIFT)    sdo = shreg[WIDTH-1];
    else if (state == PAR) sdo = par;
`else
    frame_end   = last_bit;
    if (state == SHIFT)    sdo = shreg[WIDTH-1];
`endif
  end

endmodule

// File: tb/tb_rot_serializer.sv
// tb_rot_serializer: directed checks of the framed serializer (WIDTH=8).
// Expected streams are queued per cycle and compared bit by bit.
module tb_rot_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sdo;
  logic       sdo_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic d;
    logic fs;
    logic fe;
  } exp_t;

  exp_t q[$];

`ifdef PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  always #5 clk = ~clk;

  rot_serializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .sdo         (sdo),
    .sdo_valid   (sdo_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_frame(input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.d  = w[7-i];
      e.fs = (i == 0);
      e.fe = (i == FL - 1);
      q.push_back(e);
    end
`ifdef PARITY_EN
    e.d  = ^w;
    e.fs = 1'b0;
    e.fe = 1'b1;
    q.push_back(e);
`endif
  endfunction

  task automatic send_word(input logic [7:0] w, input bit keep);
    int t;
    t = 0;
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && t < 40) begin
      step();
      t++;
    end
    chk("ready_timeout", {31'd0, din_ready}, 32'd1);
    step();
    chk("hold_full_ready", {31'd0, din_ready}, 32'd0);
    chk("hold_full_busy", {31'd0, busy}, 32'd1);
    if (!keep) din_valid = 1'b0;
  endtask

  task automatic run_stream(input int n);
    int t;
    exp_t e;
    t = 0;
    while (!sdo_valid && t < 20) begin
      step();
      t++;
    end
    chk("stream_start", {31'd0, sdo_valid}, 32'd1);
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      chk("sdo_valid", {31'd0, sdo_valid}, 32'd1);
      chk("sdo", {31'd0, sdo}, {31'd0, e.d});
      chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
      chk("frame_end", {31'd0, frame_end}, {31'd0, e.fe});
      step();
    end
    chk("stream_end_valid", {31'd0, sdo_valid}, 32'd0);
    chk("stream_end_sdo", {31'd0, sdo}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    din       = 8'hFF;
    din_valid = 1'b1;

    // 1: reset with valid held high
    repeat (3) step();
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_valid", {31'd0, sdo_valid}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_fe", {31'd0, frame_end}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);
    din_valid = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_valid", {31'd0, sdo_valid}, 32'd0);

    // 2: single frame, latency one edge after accept
    send_word(8'hA5, 1'b0);
    chk("lat_idle", {31'd0, sdo_valid}, 32'd0);
    add_frame(8'hA5);
    step();
    chk("lat_first", {31'd0, sdo_valid}, 32'd1);
    run_stream(FL);
    chk("single_busy", {31'd0, busy}, 32'd0);

    // 3: back-to-back frames, no gap
    add_frame(8'hA5);
    add_frame(8'h3C);
    fork
      begin
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
      end
      run_stream(2 * FL);
    join
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // 4: valid held for three words
    add_frame(8'h11);
    add_frame(8'hC3);
    add_frame(8'h7E);
    fork
      begin
        send_word(8'h11, 1'b1);
        send_word(8'hC3, 1'b1);
        send_word(8'h7E, 1'b0);
      end
      run_stream(3 * FL);
    join
    chk("three_busy", {31'd0, busy}, 32'd0);
    chk("three_ready", {31'd0, din_ready}, 32'd1);

    // 5: reset mid-frame then clean frame
    send_word(8'hF0, 1'b0);
    step();
    chk("f0_b0", {31'd0, sdo}, 32'd1);
    step();
    step();
    chk("f0_b2", {31'd0, sdo}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_valid", {31'd0, sdo_valid}, 32'd0);
    chk("abort_sdo", {31'd0, sdo}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, din_ready}, 32'd1);
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("no_resume", {31'd0, sdo_valid}, 32'd0);
    add_frame(8'h81);
    send_word(8'h81, 1'b0);
    run_stream(FL);

`ifdef PARITY_EN
    // 6: parity trailer values
    add_frame(8'hA5);
    add_frame(8'h07);
    chk("par_a5_model", {31'd0, q[8].d}, 32'd0);
    chk("par_07_model", {31'd0, q[17].d}, 32'd1);
    fork
      begin
        send_word(8'hA5, 1'b0);
        send_word(8'h07, 1'b0);
      end
      run_stream(2 * FL);
    join
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
